// File: rtl/control_contador_pkg.sv
// Shared definitions for the sequence controller: state encodings, sequence
// table, lap length and the table lookup helper.
package control_contador_pkg;

  localparam int unsigned LONG      = 8;  // entries per lap
  localparam int unsigned ANCHO_IDX = 3;  // position index width
  localparam int unsigned ANCHO_Q   = 4;  // sequence value width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

  localparam logic [ANCHO_Q-1:0] SEQ0 = 4'd15;
  localparam logic [ANCHO_Q-1:0] SEQ1 = 4'd9;
  localparam logic [ANCHO_Q-1:0] SEQ2 = 4'd15;
  localparam logic [ANCHO_Q-1:0] SEQ3 = 4'd1;
  localparam logic [ANCHO_Q-1:0] SEQ4 = 4'd14;
  localparam logic [ANCHO_Q-1:0] SEQ5 = 4'd8;
  localparam logic [ANCHO_Q-1:0] SEQ6 = 4'd6;
  localparam logic [ANCHO_Q-1:0] SEQ7 = 4'd0;

  // Sequence value shown at a given position.
  function automatic logic [ANCHO_Q-1:0] valor_seq(input logic [ANCHO_IDX-1:0] idx);
    logic [ANCHO_Q-1:0] v;
    case (idx)
      3'd0:    v = SEQ0;
      3'd1:    v = SEQ1;
      3'd2:    v = SEQ2;
      3'd3:    v = SEQ3;
      3'd4:    v = SEQ4;
      3'd5:    v = SEQ5;
      3'd6:    v = SEQ6;
      default: v = SEQ7;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/indice_seq.sv
// 3-bit up/down wrapping position counter.
// Ports: C clock, R sync active-high reset, en advance enable, dir 1=down,
//        idx registered position, idx_sig_c next position, wrap_c boundary
//        crossing on this edge (7->0 up, 0->7 down).
module indice_seq
  import control_contador_pkg::*;
(
  input  logic                 C,
  input  logic                 R,
  input  logic                 en,
  input  logic                 dir,
  output logic [ANCHO_IDX-1:0] idx,
  output logic [ANCHO_IDX-1:0] idx_sig_c,
  output logic                 wrap_c
);

  localparam logic [ANCHO_IDX-1:0] IDX_MAX = ANCHO_IDX'(LONG - 1);

  // Next position and wrap detection.
  always_comb begin
    idx_sig_c = idx;
    wrap_c    = 1'b0;
    if (en) begin
      if (dir) begin
        idx_sig_c = (idx == '0) ? IDX_MAX : idx - ANCHO_IDX'(1);
        wrap_c    = (idx == '0);
      end else begin
        idx_sig_c = (idx == IDX_MAX) ? '0 : idx + ANCHO_IDX'(1);
        wrap_c    = (idx == IDX_MAX);
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) idx <= '0;
    else   idx <= idx_sig_c;
  end

endmodule

// File: rtl/control_contador.sv
// Sequence controller for the arbitrary-count counter (15,9,15,1,14,8,6,0).
// Free-run, bounded run of N laps, pause and single-step.
// Ports: C clock, R sync active-high reset, START/STOP/STEP controls
//        (priority R > STOP > START > STEP), N lap limit (0 = forever),
//        Q sequence value, IDX position, VUELTAS completed laps, BUSY in RUN,
//        FIN one-cycle pulse at the end of a bounded run. All outputs registered.
// Optional macro CONTROL_CONTADOR_DIR_EN adds input DIR (1 = count down).
module control_contador
  import control_contador_pkg::*;
#(
  parameter int unsigned ANCHO_V = 4
) (
  input  logic                 C,
  input  logic                 R,
  input  logic                 START,
  input  logic                 STOP,
  input  logic                 STEP,
  input  logic [ANCHO_V-1:0]   N,
`ifdef CONTROL_CONTADOR_DIR_EN
  input  logic                 DIR,
`endif
  output logic [ANCHO_Q-1:0]   Q,
  output logic [ANCHO_IDX-1:0] IDX,
  output logic [ANCHO_V-1:0]   VUELTAS,
  output logic                 BUSY,
  output logic                 FIN
);

  estado_t              estado, estado_n;
  logic [ANCHO_V-1:0]   limite, limite_n;
  logic [ANCHO_V-1:0]   vueltas_n, vueltas_inc;
  logic                 primero, primero_n;
  logic                 avance_c;
  logic                 dir;
  logic                 wrap_c;
  logic [ANCHO_IDX-1:0] idx_sig_c;

`ifdef CONTROL_CONTADOR_DIR_EN
  assign dir = DIR;
`else
  assign dir = 1'b0;
`endif

  indice_seq u_indice (
    .C         (C),
    .R         (R),
    .en        (avance_c),
    .dir       (dir),
    .idx       (IDX),
    .idx_sig_c (idx_sig_c),
    .wrap_c    (wrap_c)
  );

  // Advance decision kept apart from the FSM so wrap_c feeds back without a loop.
  always_comb begin
    avance_c = 1'b0;
    case (estado)
      IDLE:    avance_c = !STOP && !START && STEP;
      RUN:     avance_c = !STOP;
      default: avance_c = 1'b0;
    endcase
  end

  assign vueltas_inc = VUELTAS + ANCHO_V'(1);

  // Next state, lap counter and limit.
  always_comb begin
    estado_n  = estado;
    limite_n  = limite;
    vueltas_n = VUELTAS;
    primero_n = primero;
    case (estado)
      IDLE: begin
        if (!STOP && START) begin
          estado_n  = RUN;
          limite_n  = N;
          vueltas_n = '0;
          primero_n = 1'b1;
        end
      end
      RUN: begin
        if (STOP) begin
          estado_n = IDLE;
        end else begin
          primero_n = 1'b0;
          // A reverse run starting at 0 leaves through 0->7 on its first step;
          // that departure is not a completed lap.
          if (wrap_c && !(primero && dir)) begin
            vueltas_n = vueltas_inc;
            if (limite != '0 && vueltas_inc == limite) estado_n = DONE;
          end
        end
      end
      DONE:    estado_n = IDLE;
      default: estado_n = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      estado  <= IDLE;
      limite  <= '0;
      primero <= 1'b0;
      VUELTAS <= '0;
      Q       <= SEQ0;
      BUSY    <= 1'b0;
      FIN     <= 1'b0;
    end else begin
      estado  <= estado_n;
      limite  <= limite_n;
      primero <= primero_n;
      VUELTAS <= vueltas_n;
      Q       <= valor_seq(idx_sig_c);
      BUSY    <= (estado_n == RUN);
      FIN     <= (estado_n == DONE);
    end
  end

endmodule

// File: tb/tb_control_contador.sv
// Scoreboard bench for control_contador: stimulus pushes the expected output
// set per cycle, a monitor pops and compares on the falling edge.
module tb_control_contador;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       STEP = 1'b0;
  logic [3:0] N = 4'd0;
  logic       dir = 1'b0;
  logic [3:0] Q;
  logic [2:0] IDX;
  logic [3:0] VUELTAS;
  logic       BUSY;
  logic       FIN;

  typedef struct {
    logic [3:0] q;
    logic [2:0] idx;
    logic [3:0] v;
    logic       b;
    logic       f;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic [3:0] tab [8] = '{4'd15, 4'd9, 4'd15, 4'd1, 4'd14, 4'd8, 4'd6, 4'd0};

  control_contador #(.ANCHO_V(4)) dut (
    .C       (C),
    .R       (R),
    .START   (START),
    .STOP    (STOP),
    .STEP    (STEP),
    .N       (N),
`ifdef CONTROL_CONTADOR_DIR_EN
    .DIR     (dir),
`endif
    .Q       (Q),
    .IDX     (IDX),
    .VUELTAS (VUELTAS),
    .BUSY    (BUSY),
    .FIN     (FIN)
  );

  always #5 C = ~C;

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge C);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (Q !== e.q || IDX !== e.idx || VUELTAS !== e.v || BUSY !== e.b || FIN !== e.f) begin
          failures++;
          $display("FAIL %s: got Q=%0d IDX=%0d V=%0d BUSY=%0b FIN=%0b required Q=%0d IDX=%0d V=%0d BUSY=%0b FIN=%0b",
                   e.nm, Q, IDX, VUELTAS, BUSY, FIN, e.q, e.idx, e.v, e.b, e.f);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic ck(input logic r, input logic st, input logic sp, input logic stp,
                    input logic [3:0] n, input logic d,
                    input logic [2:0] ei, input logic [3:0] ev,
                    input logic eb, input logic ef, input string nm);
    exp_t e;
    R = r; START = st; STOP = sp; STEP = stp; N = n; dir = d;
    @(posedge C);
    e.q = tab[ei]; e.idx = ei; e.v = ev; e.b = eb; e.f = ef; e.nm = nm;
    sb.push_back(e);
    @(negedge C);
  endtask

  initial begin
    // Reset and idle hold.
    ck(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, "reset");
    for (int i = 0; i < 5; i++) ck(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, "idle_hold");

    // Three single steps: 9, 15, 1.
    for (int i = 1; i <= 3; i++) ck(0, 0, 0, 1, 0, 0, 3'(i), 0, 0, 0, "step");
    ck(0, 0, 0, 0, 0, 0, 3'd3, 0, 0, 0, "step_hold");

    // Bounded run N=2 from IDX=0: FIN on the 16th advance.
    ck(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, "reset2");
    ck(0, 1, 0, 0, 4'd2, 0, 3'd0, 0, 1, 0, "run2_start");
    for (int k = 1; k <= 16; k++)
      ck(0, 0, 0, 0, 4'd7, 0, 3'(k % 8), 4'(k / 8), (k < 16), (k == 16), "run2");
    ck(0, 0, 0, 0, 0, 0, 3'd0, 4'd2, 0, 0, "run2_idle");

    // N=1 run; START during DONE is ignored.
    ck(0, 1, 0, 0, 4'd1, 0, 3'd0, 0, 1, 0, "run1_start");
    for (int k = 1; k <= 8; k++)
      ck(0, 0, 0, 0, 0, 0, 3'(k % 8), 4'(k / 8), (k < 8), (k == 8), "run1");
    ck(0, 1, 0, 0, 4'd3, 0, 3'd0, 4'd1, 0, 0, "done_start_ignored");
    ck(0, 0, 0, 0, 0, 0, 3'd0, 4'd1, 0, 0, "run1_idle");

    // Free run, STOP at IDX=5, resume.
    ck(0, 1, 0, 0, 4'd0, 0, 3'd0, 0, 1, 0, "free_start");
    for (int k = 1; k <= 5; k++) ck(0, 0, 0, 0, 0, 0, 3'(k), 0, 1, 0, "free");
    ck(0, 0, 1, 0, 0, 0, 3'd5, 0, 0, 0, "stop");
    ck(0, 0, 0, 0, 0, 0, 3'd5, 0, 0, 0, "stop_hold");
    ck(0, 1, 0, 0, 4'd0, 0, 3'd5, 0, 1, 0, "resume_start");
    ck(0, 0, 0, 0, 0, 0, 3'd6, 0, 1, 0, "resume_q6");
    ck(0, 0, 0, 0, 0, 0, 3'd7, 0, 1, 0, "resume");
    ck(0, 0, 0, 0, 0, 0, 3'd0, 4'd1, 1, 0, "resume_wrap");
    for (int k = 1; k <= 4; k++) ck(0, 0, 0, 0, 0, 0, 3'(k), 4'd1, 1, 0, "resume");

    // Reset mid-run at IDX=4 wins over START; no FIN afterwards.
    ck(1, 1, 0, 0, 4'd1, 0, 3'd0, 0, 0, 0, "reset_midrun");
    ck(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, "reset_nofin");

    // START+STOP+STEP together in IDLE: STOP wins.
    ck(0, 0, 0, 1, 0, 0, 3'd1, 0, 0, 0, "step_a");
    ck(0, 0, 0, 1, 0, 0, 3'd2, 0, 0, 0, "step_b");
    ck(0, 1, 1, 1, 4'd3, 0, 3'd2, 0, 0, 0, "all_three");
    ck(0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0, "all_three_hold");

    // Stepping across the 7->0 wrap leaves the lap count alone.
    for (int k = 3; k <= 8; k++) ck(0, 0, 0, 1, 0, 0, 3'(k % 8), 0, 0, 0, "step_wrap");

`ifdef CONTROL_CONTADOR_DIR_EN
    // Reverse bounded run N=1 from IDX=0, ends at IDX=7.
    ck(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, "rev_reset");
    ck(0, 1, 0, 0, 4'd1, 1, 3'd0, 0, 1, 0, "rev_start");
    for (int k = 1; k <= 9; k++)
      ck(0, 0, 0, 0, 0, 1, 3'((16 - k) % 8), 4'(k / 9), (k < 9), (k == 9), "rev_run");
    ck(0, 0, 0, 0, 0, 1, 3'd7, 4'd1, 0, 0, "rev_idle");
    ck(0, 0, 0, 1, 0, 1, 3'd6, 4'd1, 0, 0, "rev_step");
`endif

    R = 0; START = 0; STOP = 0; STEP = 0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge C);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
